// File: rtl/multdiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_pkg
//  Purpose  : Shared definitions for the iterative multiply/divide engine:
//             FSM state encoding, default operand width and the ALU op codes
//             that pipeline control uses to select mul/div.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multdiv_pkg;

   localparam int DEFAULT_WIDTH = 32;

   // ALU op codes shared with pipeline control
   localparam logic [4:0] ALU_MUL = 5'd6;
   localparam logic [4:0] ALU_DIV = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_unit_booth4_recode.sv
`default_nettype none
// ============================================================================
//  Module   : booth4_recode
//  Purpose  : Radix-4 Booth recoder. Maps a 3-bit multiplier window to a
//             partial product of {0,+1,+2,-1,-2} x multiplicand.
//  Ports    : bits   in  3        overlapping multiplier window {b(i+1),b(i),b(i-1)}
//             mcand  in  WIDTH    signed multiplicand
//             pp     out WIDTH+2  signed partial product (two guard bits)
//  Revision : 1.0 - initial release
// ============================================================================
module booth4_recode
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [2:0]       bits,
   input  logic [WIDTH-1:0] mcand,
   output logic [WIDTH+1:0] pp
);

   logic [WIDTH+1:0] m1;
   logic [WIDTH+1:0] m2;

   // Two guard bits let +/-2 x INT_MIN be represented without wrapping
   assign m1 = {{2{mcand[WIDTH-1]}}, mcand};
   assign m2 = {m1[WIDTH:0], 1'b0};

   always_comb begin
      pp = '0;
      case (bits)
         3'b001, 3'b010: pp = m1;
         3'b011:         pp = m2;
         3'b100:         pp = -m2;
         3'b101, 3'b110: pp = -m1;
         default:        pp = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_unit
//  Purpose  : Iterative signed multiply (radix-4 Booth, WIDTH/2 steps) and
//             restoring divide on magnitudes (WIDTH steps) for the execute
//             stage. Stalls the pipeline via busy, returns result with a
//             one-cycle ready pulse.
//  Ports    : clock          in  1      rising-edge clock
//             reset          in  1      synchronous, active-high
//             data_operandA  in  WIDTH  multiplicand / dividend
//             data_operandB  in  WIDTH  multiplier / divisor
//             ctrl_MULT      in  1      level request: multiply (priority)
//             ctrl_DIV       in  1      level request: divide
//             data_result    out WIDTH  low product bits or quotient
//             data_exception out 1      overflow / divide-by-zero
//             data_resultRDY out 1      one-cycle result-valid pulse
//             busy           out 1      high while iterating
//  Revision : 1.0 - initial release
// ============================================================================
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int              CW        = $clog2(WIDTH);
   // Product register: {accumulator with 2 guard bits, multiplier, Booth bit}
   localparam int              PW        = 2*WIDTH + 3;
   localparam logic [CW-1:0]   MULT_LAST = CW'(WIDTH/2 - 1);
   localparam logic [CW-1:0]   DIV_LAST  = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] INT_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

   state_t           state;
   state_t           state_next;
   logic [CW-1:0]    count;

   logic [PW-1:0]    prod;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic             div_neg;
   logic             div_zero;
   logic             div_ovf;

   logic [WIDTH+1:0] pp;
   logic [WIDTH+1:0] acc_sum;
   logic [PW-1:0]    prod_next;
   logic [WIDTH:0]   ovf_bits;
   logic             mult_ovf;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH-1:0] quo_next;
   logic [WIDTH-1:0] rem_next;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;

   // ---------------- multiply datapath ----------------
   booth4_recode #(.WIDTH(WIDTH)) u_recode (
      .bits  (prod[2:0]),
      .mcand (mcand),
      .pp    (pp)
   );

   assign acc_sum   = prod[PW-1:WIDTH+1] + pp;
   assign prod_next = PW'($signed({acc_sum, prod[WIDTH:0]}) >>> 2);
   // After the final shift the 2W-bit product sits at prod[2W:1];
   // signed overflow iff product bits [2W-1:W-1] are not all equal.
   assign ovf_bits  = prod_next[2*WIDTH:WIDTH];
   assign mult_ovf  = ~((&ovf_bits) | ~(|ovf_bits));

   // ---------------- divide datapath ----------------
   // Negation of INT_MIN yields the same bit pattern, which read unsigned
   // is exactly its magnitude 2^(WIDTH-1).
   assign abs_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
   assign abs_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
   assign div_shift = {rem, quo[WIDTH-1]};
   assign div_diff  = div_shift - {1'b0, dvs};
   assign quo_next  = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
   assign rem_next  = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];

   // ---------------- FSM ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: begin
            if (ctrl_MULT) begin
               state_next = ST_MULT;
            end else if (ctrl_DIV) begin
               state_next = ST_DIV;
            end
         end
         ST_MULT: if (count == MULT_LAST) state_next = ST_DONE;
         ST_DIV:  if (count == DIV_LAST)  state_next = ST_DONE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy           = (state == ST_MULT) || (state == ST_DIV);
      data_resultRDY = (state == ST_DONE);
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         count          <= '0;
         data_result    <= '0;
         data_exception <= 1'b0;
         prod           <= '0;
         mcand          <= '0;
         quo            <= '0;
         rem            <= '0;
         dvs            <= '0;
         div_neg        <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               count <= '0;
               if (ctrl_MULT) begin
                  prod  <= {{(WIDTH+2){1'b0}}, data_operandB, 1'b0};
                  mcand <= data_operandA;
               end else if (ctrl_DIV) begin
                  quo      <= abs_a;
                  dvs      <= abs_b;
                  rem      <= '0;
                  div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                  div_zero <= (data_operandB == '0);
                  div_ovf  <= (data_operandA == INT_MIN) && (&data_operandB);
               end
            end
            ST_MULT: begin
               prod  <= prod_next;
               count <= count + 1'b1;
               if (count == MULT_LAST) begin
                  data_result    <= prod_next[WIDTH:1];
                  data_exception <= mult_ovf;
               end
            end
            ST_DIV: begin
               quo   <= quo_next;
               rem   <= rem_next;
               count <= count + 1'b1;
               if (count == DIV_LAST) begin
                  // Divide-by-zero forces 0; INT_MIN/-1 naturally yields INT_MIN
                  data_result    <= div_zero ? '0 : (div_neg ? -quo_next : quo_next);
                  data_exception <= div_zero | div_ovf;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
